// File: rtl/i2c_reg_seq_if.sv
// Bundle between the register-access sequencer, its requester and the
// simple I2C byte master.
//
// Signals:
//   req_valid/req_ready/req_rw/req_dev/req_reg/req_wdata : request handshake
//   rsp_valid/rsp_rdata/rsp_err                          : completion report
//   i2c_write/i2c_cmd/i2c_data_in/i2c_clock_divisor      : commands to master
//   i2c_ready/i2c_done_tick/i2c_ack/i2c_data_out         : master status
//
// Modports:
//   master : the sequencer, which masters the command stream
//   slave  : the environment (requester plus I2C byte master)
interface i2c_reg_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [6:0]  req_dev;
  logic [7:0]  req_reg;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [1:0]  rsp_err;
  logic        i2c_write;
  logic [2:0]  i2c_cmd;
  logic [7:0]  i2c_data_in;
  logic [15:0] i2c_clock_divisor;
  logic        i2c_ready;
  logic        i2c_done_tick;
  logic        i2c_ack;
  logic [7:0]  i2c_data_out;

  modport master (
    input  req_valid, req_rw, req_dev, req_reg, req_wdata,
    input  i2c_ready, i2c_done_tick, i2c_ack, i2c_data_out,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output i2c_write, i2c_cmd, i2c_data_in, i2c_clock_divisor
  );

  modport slave (
    output req_valid, req_rw, req_dev, req_reg, req_wdata,
    output i2c_ready, i2c_done_tick, i2c_ack, i2c_data_out,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  i2c_write, i2c_cmd, i2c_data_in, i2c_clock_divisor
  );
endinterface

// File: rtl/i2c_reg_seq.sv
// Register-access transaction sequencer in front of the simple I2C master.
// Turns one request (single-byte register write or read) into the master's
// command stream and reports read data plus a status code.
//
// Ports:
//   clk      : system clock
//   reset_n  : synchronous, active-low reset
//   bus      : i2c_reg_seq_if.master (request, response and master command/status)
//
// rsp_err: 00 ok, 01 address NACK, 10 register/data NACK, 11 timeout.
module i2c_reg_seq #(
  parameter logic [15:0] CLK_DIV = 16'd120,
  parameter logic [19:0] TIMEOUT = 20'd1000000
) (
  input logic           clk,
  input logic           reset_n,
  i2c_reg_seq_if.master bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, BUSY, WAIT, RESP} state_t;
  typedef enum logic [2:0] {
    ST_START, ST_ADDR_W, ST_REG, ST_WDATA, ST_RESTART, ST_ADDR_R, ST_READ, ST_STOP
  } step_t;

  state_t      state_q, state_d;
  step_t       step_q, step_d;
  logic [19:0] cnt_q;
  logic        ready_q;
  logic        rw_q;
  logic [6:0]  dev_q;
  logic [7:0]  reg_q;
  logic [7:0]  wdata_q;
  logic [2:0]  cmd_q;
  logic [7:0]  data_q;
  logic [7:0]  rdata_q;
  logic [1:0]  err_q;
  logic [2:0]  step_cmd;
  logic [7:0]  step_data;
  logic        data_step;
  logic        accept;
  logic        strobe;
  logic        step_done;
  logic        step_entry;
  logic        tmo;
  logic        nack_addr;
  logic        nack_data;

  // Command and byte belonging to the current step. Control steps keep the
  // previously sent byte so i2c_data_in never changes on their strobe.
  always_comb begin
    step_cmd  = 3'd4;
    step_data = data_q;
    case (step_q)
      ST_START:   step_cmd  = 3'd0;
      ST_ADDR_W:  step_data = {dev_q, 1'b0};
      ST_REG:     step_data = reg_q;
      ST_WDATA:   step_data = wdata_q;
      ST_RESTART: step_cmd  = 3'd1;
      ST_ADDR_R:  step_data = {dev_q, 1'b1};
      ST_READ: begin
        step_cmd  = 3'd3;
        step_data = 8'h01;          // NACK the single read byte
      end
      ST_STOP:    step_cmd  = 3'd2;
      default:    step_cmd  = 3'd2;
    endcase
  end

  assign data_step = (step_cmd == 3'd3) || (step_cmd == 3'd4);

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    accept    = 1'b0;
    strobe    = 1'b0;
    step_done = 1'b0;
    tmo       = 1'b0;
    nack_addr = 1'b0;
    nack_data = 1'b0;
    case (state_q)
      IDLE: begin
        if (ready_q && bus.req_valid) begin
          accept  = 1'b1;
          state_d = ISSUE;
          step_d  = ST_START;
        end
      end
      ISSUE, BUSY, WAIT: begin
        // Timeout wins over anything else; master state is unknown, so no stop.
        if (cnt_q >= TIMEOUT - 20'd1) begin
          tmo     = 1'b1;
          state_d = RESP;
        end else if (state_q == ISSUE) begin
          if (bus.i2c_ready) begin
            strobe  = 1'b1;
            state_d = BUSY;
          end
        end else if (state_q == BUSY) begin
          if (!bus.i2c_ready) state_d = WAIT;
        end else begin
          step_done = data_step ? bus.i2c_done_tick : bus.i2c_ready;
        end
        if (step_done) begin
          state_d = ISSUE;
          case (step_q)
            ST_START:  step_d = ST_ADDR_W;
            ST_ADDR_W: begin
              nack_addr = bus.i2c_ack;
              step_d    = bus.i2c_ack ? ST_STOP : ST_REG;
            end
            ST_REG: begin
              nack_data = bus.i2c_ack;
              if (bus.i2c_ack) step_d = ST_STOP;
              else             step_d = rw_q ? ST_RESTART : ST_WDATA;
            end
            ST_WDATA: begin
              nack_data = bus.i2c_ack;
              step_d    = ST_STOP;
            end
            ST_RESTART: step_d = ST_ADDR_R;
            ST_ADDR_R: begin
              nack_addr = bus.i2c_ack;
              step_d    = bus.i2c_ack ? ST_STOP : ST_READ;
            end
            ST_READ:  step_d  = ST_STOP;  // ack here is the master's own NACK
            ST_STOP:  state_d = RESP;
            default:  state_d = RESP;
          endcase
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign step_entry = (state_d == ISSUE) && (state_q != ISSUE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      step_q  <= ST_START;
      cnt_q   <= 20'd0;
      ready_q <= 1'b0;
      cmd_q   <= 3'd0;
      data_q  <= 8'd0;
      rdata_q <= 8'd0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      ready_q <= (state_d == IDLE);
      if (step_entry)
        cnt_q <= 20'd0;
      else if (state_q inside {ISSUE, BUSY, WAIT})
        cnt_q <= cnt_q + 20'd1;
      if (strobe) begin
        cmd_q  <= step_cmd;
        data_q <= step_data;
      end
      if (accept) begin
        rdata_q <= 8'd0;
        err_q   <= 2'b00;
      end
      if (tmo)            err_q <= 2'b11;
      else if (nack_addr) err_q <= 2'b01;
      else if (nack_data) err_q <= 2'b10;
      if (step_done && (step_q == ST_READ)) rdata_q <= bus.i2c_data_out;
    end
  end

  // Request fields are captured once; later changes on the bus are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      rw_q    <= bus.req_rw;
      dev_q   <= bus.req_dev;
      reg_q   <= bus.req_reg;
      wdata_q <= bus.req_wdata;
    end
  end

  assign bus.req_ready         = ready_q;
  assign bus.rsp_valid         = (state_q == RESP);
  assign bus.rsp_rdata         = rdata_q;
  assign bus.rsp_err           = err_q;
  assign bus.i2c_write         = strobe;
  assign bus.i2c_cmd           = strobe ? step_cmd  : cmd_q;
  assign bus.i2c_data_in       = strobe ? step_data : data_q;
  assign bus.i2c_clock_divisor = CLK_DIV;

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Self-checking bench for i2c_reg_seq: a behavioural I2C byte-master model
// answers the command strobes, and a reference model derives the expected
// strobe list, status and read data from the transaction rules.
module tb_i2c_reg_seq;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  i2c_reg_seq_if bus();

  i2c_reg_seq #(.CLK_DIV(16'd120), .TIMEOUT(20'd100)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Master model configuration and observations
  logic        m_hang;
  int          m_nack;
  int          m_wr;
  logic [7:0]  m_rbyte;
  logic [10:0] log_q[$];
  int          rsp_cnt = 0;
  logic [7:0]  rsp_rdata_s;
  logic [1:0]  rsp_err_s;
  int          last_lat;

  // Behavioural byte master: all activity on the falling edge.
  initial begin
    int       phase;
    int       dly;
    logic [2:0] mcmd;
    phase = 0; dly = 0; mcmd = 3'd0;
    bus.i2c_ready = 1'b1; bus.i2c_done_tick = 1'b0;
    bus.i2c_ack = 1'b0; bus.i2c_data_out = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        bus.i2c_ready = 1'b1;
        bus.i2c_done_tick = 1'b0;
        phase = 0;
      end else begin
        bus.i2c_done_tick = 1'b0;
        if (phase == 0) begin
          if (bus.i2c_write) begin
            log_q.push_back({bus.i2c_cmd, bus.i2c_data_in});
            mcmd = bus.i2c_cmd;
            if (mcmd == 3'd4) m_wr++;
            phase = 1;
          end
        end else if (phase == 1) begin
          bus.i2c_ready = 1'b0;
          dly = $urandom_range(2, 6);
          phase = 2;
        end else if (!(m_hang && mcmd == 3'd0)) begin
          if (dly > 0) dly--;
          else begin
            bus.i2c_ready = 1'b1;
            if (mcmd == 3'd3 || mcmd == 3'd4) begin
              bus.i2c_done_tick = 1'b1;
              bus.i2c_ack = (mcmd == 3'd3) || (m_wr == m_nack);
              bus.i2c_data_out = (mcmd == 3'd3) ? m_rbyte : 8'($urandom);
            end
            phase = 0;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        rsp_cnt++;
        rsp_rdata_s = bus.rsp_rdata;
        rsp_err_s   = bus.rsp_err;
      end
    end
  end

  // Reference model: expected strobes {cmd,data}, status and read data.
  logic [10:0] exp_q[$];
  logic [1:0]  exp_err;
  logic [7:0]  exp_rdata;

  task automatic build_expected(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                                input logic [7:0] wd, input int nack, input logic hang,
                                input logic [7:0] rbyte);
    logic [11:0] plan[$];   // {is_address_byte, cmd, data}
    int nw;
    bit stop;
    exp_q.delete();
    exp_err = 2'b00; exp_rdata = 8'h00; nw = 0; stop = 0;
    exp_q.push_back({3'd0, 8'h00});
    if (hang) begin
      exp_err = 2'b11;
      return;
    end
    plan.push_back({1'b1, 3'd4, dev, 1'b0});
    plan.push_back({1'b0, 3'd4, rg});
    if (rw) begin
      plan.push_back({1'b0, 3'd1, 8'h00});
      plan.push_back({1'b1, 3'd4, dev, 1'b1});
      plan.push_back({1'b0, 3'd3, 8'h01});
    end else begin
      plan.push_back({1'b0, 3'd4, wd});
    end
    for (int i = 0; i < plan.size() && !stop; i++) begin
      exp_q.push_back(plan[i][10:0]);
      if (plan[i][10:8] == 3'd4) begin
        nw++;
        if (nw == nack) begin
          exp_err = plan[i][11] ? 2'b01 : 2'b10;
          stop = 1;
        end
      end else if (plan[i][10:8] == 3'd3) begin
        exp_rdata = rbyte;
      end
    end
    exp_q.push_back({3'd2, 8'h00});
  endtask

  task automatic wait_ready(input string name);
    int w;
    w = 0;
    while (!bus.req_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check({name, "_ready"}, bus.req_ready, 1);
  endtask

  task automatic run_req(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] wd, input logic [7:0] rbyte, input int nack,
                         input logic hang, input string name);
    int c, r0;
    build_expected(rw, dev, rg, wd, nack, hang, rbyte);
    m_nack = nack; m_hang = hang; m_rbyte = rbyte; m_wr = 0;
    log_q.delete();
    wait_ready(name);
    r0 = rsp_cnt;
    bus.req_valid = 1'b1; bus.req_rw = rw; bus.req_dev = dev;
    bus.req_reg = rg; bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_rw = 1'($urandom); bus.req_dev = 7'($urandom);
    bus.req_reg = 8'($urandom); bus.req_wdata = 8'($urandom);
    c = 0;
    while (rsp_cnt == r0 && c < 3000) begin
      @(posedge clk); #1;
      c++;
    end
    last_lat = c;
    check({name, "_done"}, rsp_cnt != r0, 1);
    repeat (6) @(posedge clk);
    #1;
    check({name, "_nrsp"}, rsp_cnt - r0, 1);
    check({name, "_err"}, rsp_err_s, exp_err);
    check({name, "_rdata"}, rsp_rdata_s, exp_rdata);
    check({name, "_err_held"}, bus.rsp_err, exp_err);
    check({name, "_rdata_held"}, bus.rsp_rdata, exp_rdata);
    check({name, "_nstrobe"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check($sformatf("%s_cmd%0d", name, i), log_q[i][10:8], exp_q[i][10:8]);
      if (exp_q[i][10:8] >= 3'd3)
        check($sformatf("%s_data%0d", name, i), log_q[i][7:0], exp_q[i][7:0]);
    end
  endtask

  int r0;
  int w;

  initial begin
    reset_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_rw = 1'b0; bus.req_dev = 7'd0;
    bus.req_reg = 8'd0; bus.req_wdata = 8'd0;
    m_hang = 1'b0; m_nack = 0; m_wr = 0; m_rbyte = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_i2c_write", bus.i2c_write, 0);
    check("rst_i2c_cmd", bus.i2c_cmd, 0);
    check("rst_i2c_data_in", bus.i2c_data_in, 0);
    check("clock_divisor", bus.i2c_clock_divisor, 16'd120);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", bus.req_ready, 1);

    run_req(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 0, 1'b0, "wr");
    run_req(1'b1, 7'h50, 8'h22, 8'h00, 8'h3C, 0, 1'b0, "rd");
    run_req(1'b0, 7'h50, 8'h10, 8'h5A, 8'h00, 1, 1'b0, "wr_nack_addr");
    run_req(1'b1, 7'h50, 8'h22, 8'h00, 8'h77, 2, 1'b0, "rd_nack_reg");
    run_req(1'b0, 7'h13, 8'h44, 8'h99, 8'h00, 3, 1'b0, "wr_nack_data");
    run_req(1'b1, 7'h6B, 8'h05, 8'h00, 8'hE1, 3, 1'b0, "rd_nack_addr_r");

    run_req(1'b0, 7'h2A, 8'h01, 8'hFF, 8'h00, 0, 1'b1, "tmo");
    check("tmo_latency_ok", last_lat <= 110, 1);

    // Recover the hung master with a system reset.
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    m_hang = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of the write-data step.
    m_nack = 0; m_wr = 0; log_q.delete();
    wait_ready("rst_mid");
    r0 = rsp_cnt;
    bus.req_valid = 1'b1; bus.req_rw = 1'b0; bus.req_dev = 7'h50;
    bus.req_reg = 8'h10; bus.req_wdata = 8'h66;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    w = 0;
    while (log_q.size() < 4 && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    check("rst_mid_reached_wdata", log_q.size() >= 4, 1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("rst_mid_req_ready", bus.req_ready, 0);
    check("rst_mid_i2c_write", bus.i2c_write, 0);
    check("rst_mid_rsp_valid", bus.rsp_valid, 0);
    @(posedge clk); #1;
    check("rst_mid_ready_again", bus.req_ready, 1);
    repeat (20) @(posedge clk);
    #1;
    check("rst_mid_no_rsp", rsp_cnt, r0);
    check("rst_mid_no_stop", log_q.size(), 4);
    run_req(1'b0, 7'h50, 8'h33, 8'hC3, 8'h00, 0, 1'b0, "wr_after_rst");

    for (int k = 0; k < 20; k++) begin
      logic       rw;
      int         nk;
      rw = 1'($urandom_range(0, 1));
      nk = $urandom_range(0, 5);
      if (nk > 3) nk = 0;
      run_req(rw, 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), nk, 1'b0,
              $sformatf("rnd%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_reg_seq.md
Name: i2c_reg_seq

Overview:
- Transaction sequencer in front of the simple I2C master.
- Converts one register-access request (write one byte, or read one byte) into the master's command stream: start, address, register, restart, read, stop.
- Drives the master's write/cmd/data_in inputs and consumes its ready/done_tick/ack/data_out outputs.
- Returns read data plus a status code to the requester.

Parameters:
- CLK_DIV, 16'd120, value driven on i2c_clock_divisor (quarter SCL period in clk cycles).
- TIMEOUT, 20'd1000000, max clk cycles waiting on any single master step before abort.

Ports:
- clk  input  1  system clock
- reset_n  input  1  synchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  sequencer can accept request
- req_rw  input  1  0 = register write, 1 = register read
- req_dev  input  7  7-bit device address
- req_reg  input  8  register address
- req_wdata  input  8  write data
- rsp_valid  output  1  one-cycle completion pulse
- rsp_rdata  output  8  read data (0 for writes)
- rsp_err  output  2  00 ok, 01 address NACK, 10 register/data NACK, 11 timeout
- i2c_write  output  1  one-cycle command strobe to master
- i2c_cmd  output  3  0 start, 1 restart, 2 stop, 3 read, 4 write
- i2c_data_in  output  8  byte to send; for read, bit0 = 1 (NACK, single byte)
- i2c_clock_divisor  output  16  constant CLK_DIV
- i2c_ready  input  1  master idle/hold, accepts command
- i2c_done_tick  input  1  byte phase complete
- i2c_ack  input  1  ack bit sampled by master; 0 = slave ACK
- i2c_data_out  input  8  received byte

Behaviour:
- Reset (reset_n = 0 at posedge clk):
  - Outputs: req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, i2c_write = 0, i2c_cmd = 0, i2c_data_in = 0.
  - State goes to IDLE; timeout counter cleared.
  - Reset mid-transaction abandons the transaction: no rsp_valid, no stop issued. The master is reset by the same system reset.
- Acceptance:
  - req_ready = 1 only in IDLE.
  - A request is accepted on a cycle with req_valid & req_ready. All req_* fields are latched that cycle; later changes are ignored.
- Step sequencer: each step runs ISSUE -> BUSY -> WAIT.
  - ISSUE: waits for i2c_ready = 1, then pulses i2c_write for exactly one cycle with i2c_cmd/i2c_data_in valid that cycle.
  - BUSY: waits for i2c_ready = 0.
  - WAIT:
    - Data steps (cmd 3/4) complete on i2c_done_tick; i2c_ack and i2c_data_out are captured that same cycle.
    - Control steps (0/1/2) complete when i2c_ready returns to 1.
  - i2c_cmd/i2c_data_in hold their last values outside strobes.
- Write sequence: START; WRITE {dev,0}; WRITE reg; WRITE wdata; STOP; RESP.
- Read sequence: START; WRITE {dev,0}; WRITE reg; RESTART; WRITE {dev,1}; READ (data_in = 8'h01); STOP; RESP.
- NACK handling (captured i2c_ack = 1 on a WRITE step):
  - Skip the remaining steps and go directly to STOP.
  - Error code: 01 if the failing byte is an address byte (either {dev,0} or {dev,1}); 10 otherwise.
  - The READ step's ack is the master's own NACK and is never an error.
- Timeout:
  - Counter resets at each step entry and increments in ISSUE/BUSY/WAIT.
  - On reaching TIMEOUT: rsp_err = 11 and the sequencer goes to RESP directly (no stop, since the master state is unknown).
- RESP:
  - rsp_valid = 1 for one cycle; rsp_rdata/rsp_err are valid that cycle and held until the next acceptance.
  - Next cycle: IDLE, req_ready = 1.
  - Back-to-back requests: minimum one IDLE cycle between rsp_valid and next acceptance.
- Error priority: timeout overrides NACK code. The first NACK wins; no further bytes are sent after it.
- Latency (write, no stretching): start + 3 bytes + stop; each byte = 9 SCL periods plus master overhead. No fixed cycle count is required; ordering and strobe rules are mandatory.

Test Plan:
- Write req dev=7'h50, reg=8'h10, wdata=8'hA5, model ACKs all -> strobes in order cmd 0, 4(8'hA0), 4(8'h10), 4(8'hA5), 2; rsp_valid once, rsp_err=00, rsp_rdata=0.
- Read req dev=7'h50, reg=8'h22, model returns 8'h3C -> strobes 0, 4(8'hA0), 4(8'h22), 1, 4(8'hA1), 3(8'h01), 2; rsp_rdata=8'h3C, rsp_err=00.
- Write, model NACKs first address byte -> next strobe is cmd 2 (no further writes); rsp_err=01.
- Read, model NACKs register byte -> strobes 0, 4, 4, 2; rsp_err=10; no restart issued.
- Model holds i2c_ready=0 after START, TIMEOUT=100 -> rsp_valid within 100 + few cycles, rsp_err=11, no stop strobe.
- reset_n low for 1 cycle during WDATA step -> next cycle req_ready=0, i2c_write=0, no rsp_valid; after release req_ready=1 and a new write completes with err=00.
